dense_layer_pipe_reg: RTL and testbench

DENSE_LAYER_PIPE_REG -- requirements
Module: dense_layer_pipe_reg

---
 rtl/dense_layer_pkg.sv | 38 +++
 rtl/dense_pipe_stage.sv | 40 ++++
 rtl/dense_layer_pipe_reg.sv | 144 ++++++++++++++
 tb/tb_dense_layer_pipe_reg.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_layer_pkg.sv
// Shared field widths, the default packed bundle type and small helpers for
// the dense-layer pipeline register.
package dense_layer_pkg;

    localparam int SIZE_DEF            = 3;
    localparam int DATA_SIZE_DEF       = 16;
    localparam int COST_TYPE_SIZE_DEF  = 8;
    localparam int DENSE_TYPE_SIZE_DEF = 4;
    localparam int ACT_TYPE_SIZE_DEF   = 4;
    localparam int DEPTH_DEF           = 1;
    localparam int DEPTH_MAX           = 16;
    localparam int INDEX_SIZE          = 32;

    // Field order here fixes the packed layout every stage carries.
    typedef struct packed {
        logic [ACT_TYPE_SIZE_DEF-1:0]          act_type;
        logic                                  backprop_cost;
        logic [COST_TYPE_SIZE_DEF-1:0]         cost_type;
        logic                                  is_update;
        logic [DATA_SIZE_DEF*SIZE_DEF-1:0]     predict_value;
        logic [INDEX_SIZE-1:0]                 w_layer_index;
        logic [INDEX_SIZE-1:0]                 w_row_index;
        logic                                  is_cost_layer;
        logic [DENSE_TYPE_SIZE_DEF-1:0]        dense_type;
        logic [DATA_SIZE_DEF*SIZE_DEF-1:0]     x;
        logic [DATA_SIZE_DEF*SIZE_DEF-1:0]     w;
    } dense_bundle_t;

    function automatic int unsigned count_valid(input logic [DEPTH_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < DEPTH_MAX; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dense_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a bundle register that loads
// whenever the stage is empty or its current contents move on this cycle.
module dense_pipe_stage
    import dense_layer_pkg::*;
#(
    parameter type bundle_t = dense_bundle_t
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    up_valid,
    input  bundle_t up_bundle,
    input  logic    down_ready,
    output logic    valid,
    output bundle_t bundle
);

    logic load;

    assign load = !valid || down_ready;

    // NOTE: the bundle register is reset as well so every output field reads
    // zero after rst; flush clears only the valid bit and leaves data as is.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            bundle <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= up_valid;
            end
            if (load && up_valid) begin
                bundle <= up_bundle;
            end
        end
    end

endmodule

// File: rtl/dense_layer_pipe_reg.sv
// DEPTH-stage elastic pipeline carrying the full dense-layer command bundle
// with valid/ready flow control, bubble collapsing, flush and occupancy.
module dense_layer_pipe_reg #(
    parameter int SIZE            = dense_layer_pkg::SIZE_DEF,
    parameter int DATA_SIZE       = dense_layer_pkg::DATA_SIZE_DEF,
    parameter int COST_TYPE_SIZE  = dense_layer_pkg::COST_TYPE_SIZE_DEF,
    parameter int DENSE_TYPE_SIZE = dense_layer_pkg::DENSE_TYPE_SIZE_DEF,
    parameter int ACT_TYPE_SIZE   = dense_layer_pkg::ACT_TYPE_SIZE_DEF,
    parameter int DEPTH           = dense_layer_pkg::DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic                           flush,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy,

    input  logic [ACT_TYPE_SIZE-1:0]       act_type,
    output logic [ACT_TYPE_SIZE-1:0]       act_type_out,
    input  logic                           backprop_cost,
    output logic                           backprop_cost_out,
    input  logic [COST_TYPE_SIZE-1:0]      cost_type,
    output logic [COST_TYPE_SIZE-1:0]      cost_type_out,
    input  logic                           is_update,
    output logic                           is_update_out,
    input  logic [DATA_SIZE*SIZE-1:0]      predict_value,
    output logic [DATA_SIZE*SIZE-1:0]      predict_value_out,
    input  logic [31:0]                    w_layer_index,
    output logic [31:0]                    w_layer_index_out,
    input  logic [31:0]                    w_row_index,
    output logic [31:0]                    w_row_index_out,
    input  logic                           is_cost_layer,
    output logic                           is_cost_layer_out,
    input  logic [DENSE_TYPE_SIZE-1:0]     dense_type,
    output logic [DENSE_TYPE_SIZE-1:0]     dense_type_out,
    input  logic [DATA_SIZE*SIZE-1:0]      x,
    output logic [DATA_SIZE*SIZE-1:0]      x_out,
    input  logic [DATA_SIZE*SIZE-1:0]      w,
    output logic [DATA_SIZE*SIZE-1:0]      w_out
);

    import dense_layer_pkg::*;

    localparam int OCC_W = $clog2(DEPTH+1);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("dense_layer_pipe_reg: DEPTH must be in 1..16");
    end

    // Same layout as dense_bundle_t, resized to this instance's parameters.
    typedef struct packed {
        logic [ACT_TYPE_SIZE-1:0]   act_type;
        logic                       backprop_cost;
        logic [COST_TYPE_SIZE-1:0]  cost_type;
        logic                       is_update;
        logic [DATA_SIZE*SIZE-1:0]  predict_value;
        logic [INDEX_SIZE-1:0]      w_layer_index;
        logic [INDEX_SIZE-1:0]      w_row_index;
        logic                       is_cost_layer;
        logic [DENSE_TYPE_SIZE-1:0] dense_type;
        logic [DATA_SIZE*SIZE-1:0]  x;
        logic [DATA_SIZE*SIZE-1:0]  w;
    } bundle_t;

    bundle_t          in_bundle;
    bundle_t          stage_bundle [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] down_ready;

    assign in_bundle = '{
        act_type:      act_type,
        backprop_cost: backprop_cost,
        cost_type:     cost_type,
        is_update:     is_update,
        predict_value: predict_value,
        w_layer_index: w_layer_index,
        w_row_index:   w_row_index,
        is_cost_layer: is_cost_layer,
        dense_type:    dense_type,
        x:             x,
        w:             w
    };

    // down_ready[k] is whether stage k+1 can take stage k's bundle this cycle;
    // it is derived from registered valid bits only, so no combinational loop.
    // NOTE: always_comb uses blocking assignments and gives every bit a
    // default first, so no latch is inferred.
    always_comb begin
        down_ready             = '0;
        down_ready[DEPTH-1]    = out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            down_ready[k] = down_ready[k+1] || !stage_valid[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            dense_pipe_stage #(
                .bundle_t(bundle_t)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .up_valid   (in_valid),
                .up_bundle  (in_bundle),
                .down_ready (down_ready[k]),
                .valid      (stage_valid[k]),
                .bundle     (stage_bundle[k])
            );
        end else begin : g_body
            dense_pipe_stage #(
                .bundle_t(bundle_t)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .up_valid   (stage_valid[k-1]),
                .up_bundle  (stage_bundle[k-1]),
                .down_ready (down_ready[k]),
                .valid      (stage_valid[k]),
                .bundle     (stage_bundle[k])
            );
        end
    end

    assign in_ready  = !stage_valid[0] || down_ready[0];
    assign out_valid = stage_valid[DEPTH-1];
    assign occupancy = OCC_W'(count_valid(DEPTH_MAX'(stage_valid)));

    assign act_type_out      = stage_bundle[DEPTH-1].act_type;
    assign backprop_cost_out = stage_bundle[DEPTH-1].backprop_cost;
    assign cost_type_out     = stage_bundle[DEPTH-1].cost_type;
    assign is_update_out     = stage_bundle[DEPTH-1].is_update;
    assign predict_value_out = stage_bundle[DEPTH-1].predict_value;
    assign w_layer_index_out = stage_bundle[DEPTH-1].w_layer_index;
    assign w_row_index_out   = stage_bundle[DEPTH-1].w_row_index;
    assign is_cost_layer_out = stage_bundle[DEPTH-1].is_cost_layer;
    assign dense_type_out    = stage_bundle[DEPTH-1].dense_type;
    assign x_out             = stage_bundle[DEPTH-1].x;
    assign w_out             = stage_bundle[DEPTH-1].w;

endmodule

// File: tb/tb_dense_layer_pipe_reg.sv
// Directed bench for dense_layer_pipe_reg: a DEPTH=3 instance checked through
// a scoreboard queue and a DEPTH=4 instance for the long-stall case.
module tb_dense_layer_pipe_reg;

    import dense_layer_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dense_bundle_t drv;
    dense_bundle_t q3 [$];

    logic [3:0]  act_type;
    logic        backprop_cost;
    logic [7:0]  cost_type;
    logic        is_update;
    logic [47:0] predict_value;
    logic [31:0] w_layer_index;
    logic [31:0] w_row_index;
    logic        is_cost_layer;
    logic [3:0]  dense_type;
    logic [47:0] x;
    logic [47:0] w;

    assign act_type      = drv.act_type;
    assign backprop_cost = drv.backprop_cost;
    assign cost_type     = drv.cost_type;
    assign is_update     = drv.is_update;
    assign predict_value = drv.predict_value;
    assign w_layer_index = drv.w_layer_index;
    assign w_row_index   = drv.w_row_index;
    assign is_cost_layer = drv.is_cost_layer;
    assign dense_type    = drv.dense_type;
    assign x             = drv.x;
    assign w             = drv.w;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, flush3;
    logic [1:0]  occupancy3;
    logic [3:0]  act_type_out3;
    logic        backprop_cost_out3;
    logic [7:0]  cost_type_out3;
    logic        is_update_out3;
    logic [47:0] predict_value_out3;
    logic [31:0] w_layer_index_out3;
    logic [31:0] w_row_index_out3;
    logic        is_cost_layer_out3;
    logic [3:0]  dense_type_out3;
    logic [47:0] x_out3;
    logic [47:0] w_out3;
    dense_bundle_t out3;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, flush4;
    logic [2:0]  occupancy4;
    logic [3:0]  act_type_out4;
    logic        backprop_cost_out4;
    logic [7:0]  cost_type_out4;
    logic        is_update_out4;
    logic [47:0] predict_value_out4;
    logic [31:0] w_layer_index_out4;
    logic [31:0] w_row_index_out4;
    logic        is_cost_layer_out4;
    logic [3:0]  dense_type_out4;
    logic [47:0] x_out4;
    logic [47:0] w_out4;
    dense_bundle_t out4;

    assign out3 = {act_type_out3, backprop_cost_out3, cost_type_out3, is_update_out3,
                   predict_value_out3, w_layer_index_out3, w_row_index_out3,
                   is_cost_layer_out3, dense_type_out3, x_out3, w_out3};
    assign out4 = {act_type_out4, backprop_cost_out4, cost_type_out4, is_update_out4,
                   predict_value_out4, w_layer_index_out4, w_row_index_out4,
                   is_cost_layer_out4, dense_type_out4, x_out4, w_out4};

    dense_layer_pipe_reg #(.DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_ready(out_ready3), .flush(flush3), .occupancy(occupancy3),
        .act_type(act_type), .act_type_out(act_type_out3),
        .backprop_cost(backprop_cost), .backprop_cost_out(backprop_cost_out3),
        .cost_type(cost_type), .cost_type_out(cost_type_out3),
        .is_update(is_update), .is_update_out(is_update_out3),
        .predict_value(predict_value), .predict_value_out(predict_value_out3),
        .w_layer_index(w_layer_index), .w_layer_index_out(w_layer_index_out3),
        .w_row_index(w_row_index), .w_row_index_out(w_row_index_out3),
        .is_cost_layer(is_cost_layer), .is_cost_layer_out(is_cost_layer_out3),
        .dense_type(dense_type), .dense_type_out(dense_type_out3),
        .x(x), .x_out(x_out3), .w(w), .w_out(w_out3)
    );

    dense_layer_pipe_reg #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready4), .flush(flush4), .occupancy(occupancy4),
        .act_type(act_type), .act_type_out(act_type_out4),
        .backprop_cost(backprop_cost), .backprop_cost_out(backprop_cost_out4),
        .cost_type(cost_type), .cost_type_out(cost_type_out4),
        .is_update(is_update), .is_update_out(is_update_out4),
        .predict_value(predict_value), .predict_value_out(predict_value_out4),
        .w_layer_index(w_layer_index), .w_layer_index_out(w_layer_index_out4),
        .w_row_index(w_row_index), .w_row_index_out(w_row_index_out4),
        .is_cost_layer(is_cost_layer), .is_cost_layer_out(is_cost_layer_out4),
        .dense_type(dense_type), .dense_type_out(dense_type_out4),
        .x(x), .x_out(x_out4), .w(w), .w_out(w_out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dense_bundle_t make_bundle(input int n, input logic cost);
        dense_bundle_t b;
        b.act_type      = 4'(n);
        b.backprop_cost = n[0];
        b.cost_type     = 8'(n * 3 + 1);
        b.is_update     = n[1];
        b.predict_value = {16'(n + 100), 16'(n + 200), 16'(n + 300)};
        b.w_layer_index = 32'(n * 7);
        b.w_row_index   = 32'(n);
        b.is_cost_layer = cost;
        b.dense_type    = 4'(n ^ 5);
        b.x             = {16'(n * 2), 16'(n * 2 + 1), 16'(n * 2 + 2)};
        b.w             = {16'(n * 5), 16'(16'hA000 + n), 16'(~n)};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_bundle(input string tag, input dense_bundle_t got, input dense_bundle_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard step for the DEPTH=3 instance: inputs are already driven and
    // settled; record the handshakes of this cycle, then advance one edge.
    task automatic cyc3();
        dense_bundle_t e;
        if (!rst && out_valid3 && out_ready3) begin
            chk("sb_out3_expected", 64'(q3.size() > 0), 1);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk_bundle("sb_out3", out3, e);
            end
        end
        if (rst || flush3) q3.delete();
        else if (in_valid3 && in_ready3) q3.push_back(drv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drv = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; flush3 = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; flush4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state on both instances.
        chk("rst_out_valid3", out_valid3, 0);
        chk("rst_occ3", occupancy3, 0);
        chk_bundle("rst_out3", out3, '0);
        chk("rst_out_valid4", out_valid4, 0);
        chk("rst_occ4", occupancy4, 0);
        chk_bundle("rst_out4", out4, '0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready3", in_ready3, 1);

        // Streaming 1..10 at full rate, latency 3.
        out_ready3 = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid3 = (c < 10);
            drv = make_bundle(c + 1, c[0]);
            #1;
            chk("stream_out_valid", out_valid3, 64'(c >= 3 && c < 13));
            chk("stream_in_ready", in_ready3, 1);
            if (c >= 3 && c < 13) chk("stream_row", w_row_index_out3, 64'(c - 2));
            cyc3();
        end

        // Fill under back-pressure, then one out / one in while full.
        out_ready3 = 1'b0;
        in_valid3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drv = make_bundle(11 + c, 1'b0);
            #1;
            chk("fill_in_ready", in_ready3, 64'(c < 3));
            chk("fill_occ", occupancy3, 64'(c));
            cyc3();
        end
        out_ready3 = 1'b1;
        drv = make_bundle(14, 1'b0);
        #1;
        chk("full_in_ready", in_ready3, 1);
        chk("full_out_valid", out_valid3, 1);
        cyc3();
        out_ready3 = 1'b0;
        in_valid3 = 1'b0;
        #1;
        chk("full_occ_kept", occupancy3, 3);
        chk("full_next_row", w_row_index_out3, 12);
        chk("full_in_ready_low", in_ready3, 0);
        cyc3();
        out_ready3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            cyc3();
        end
        chk("drain_occ", occupancy3, 0);

        // Flush with two bundles in flight and an input offered.
        out_ready3 = 1'b0;
        in_valid3 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drv = make_bundle(20 + c, 1'b0);
            #1;
            cyc3();
        end
        drv = make_bundle(99, 1'b1);
        flush3 = 1'b1;
        #1;
        chk("flush_occ_pre", occupancy3, 2);
        chk("flush_out_valid_pre", out_valid3, 0);
        cyc3();
        flush3 = 1'b0;
        in_valid3 = 1'b0;
        #1;
        chk("flush_occ_post", occupancy3, 0);
        chk("flush_out_valid_post", out_valid3, 0);
        out_ready3 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("flush_no_emit", out_valid3, 0);
            cyc3();
        end

        // Mid-stream reset with cost-layer bundles, then realigned traffic.
        in_valid3 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drv = make_bundle(30 + c, 1'b1);
            #1;
            cyc3();
        end
        rst = 1'b1;
        drv = make_bundle(35, 1'b1);
        #1;
        cyc3();
        chk_bundle("midrst_out3", out3, '0);
        chk("midrst_out_valid", out_valid3, 0);
        chk("midrst_occ", occupancy3, 0);
        rst = 1'b0;
        drv = make_bundle(40, 1'b0);
        #1;
        chk("midrst_in_ready", in_ready3, 1);
        cyc3();
        drv = make_bundle(41, 1'b1);
        #1;
        cyc3();
        in_valid3 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            cyc3();
        end
        chk("midrst_drained", 64'(q3.size()), 0);

        // DEPTH=4: single bundle parked at the output, second one collapses.
        out_ready4 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid4 = (c == 0 || c == 5);
            drv = make_bundle((c == 0) ? 50 : 51, 1'b1);
            #1;
            chk("d4_out_valid", out_valid4, 64'(c >= 4));
            chk("d4_occ", occupancy4, (c == 0) ? 0 : ((c <= 5) ? 1 : 2));
            if (c >= 4) chk_bundle("d4_hold", out4, make_bundle(50, 1'b1));
            if (c == 5) chk("d4_in_ready", in_ready4, 1);
            @(posedge clk);
            #1;
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        #1;
        chk("d4_release_valid", out_valid4, 1);
        chk_bundle("d4_release_first", out4, make_bundle(50, 1'b1));
        @(posedge clk);
        #1;
        chk_bundle("d4_release_second", out4, make_bundle(51, 1'b1));
        chk("d4_release_occ", occupancy4, 1);
        @(posedge clk);
        #1;
        chk("d4_empty_valid", out_valid4, 0);
        chk("d4_empty_occ", occupancy4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
